tx_stream_arbiter: RTL

TX_STREAM_ARBITER -- requirements
Module: tx_stream_arbiter

---
 rtl/tx_stream_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/tx_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tx_stream_arbiter
//  Description : Round-robin arbiter that grants the shared TCP TX payload
//                stream to one of two AXI-Stream requesters for one whole
//                segment at a time. The payload path is zero-latency and
//                combinational. Completed segments are counted per requester,
//                and a non-contiguous tkeep is flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_stream_arbiter #(
    parameter int unsigned TCP_DATA_LENGTH = 1456,
    parameter logic [3:0]  TCP_ESTABLISHED = 4'd4
) (
    input  logic        coreclk_out,
    input  logic        reset,

    // requester 0: external user stream
    input  logic        s0_tvalid,
    output logic        s0_tready,
    input  logic [63:0] s0_tdata,
    input  logic [7:0]  s0_tkeep,

    // requester 1: test/pattern stream
    input  logic        s1_tvalid,
    output logic        s1_tready,
    input  logic [63:0] s1_tdata,
    input  logic [7:0]  s1_tkeep,

    // shared TCP TX payload stream
    output logic        tx_user_tvalid,
    input  logic        tx_user_tready,
    output logic [63:0] tx_user_tdata,
    output logic [7:0]  tx_user_tkeep,

    input  logic [3:0]  tcp_state,

    output logic        owner,
    output logic        busy,
    output logic [31:0] seg_cnt0,
    output logic [31:0] seg_cnt1,
    output logic        len_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Segment length widened to the sum width so the end-of-segment compare
    // cannot miss a crossing caused by the 16-bit counter's carry.
    localparam logic [16:0] c_seg_bytes = 17'(TCP_DATA_LENGTH);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, k[i]};
        end
        return n;
    endfunction

    // Only masks packed from bit 0 upward are legal byte enables.
    function automatic logic keep_is_contiguous(input logic [7:0] k);
        logic ok;
        case (k)
            8'h01, 8'h03, 8'h07, 8'h0F,
            8'h1F, 8'h3F, 8'h7F, 8'hFF: ok = 1'b1;
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q,    state_d;
    logic        owner_q,    owner_d;
    logic        last_q,     last_d;      // requester that finished last
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] seg0_q,     seg0_d;
    logic [31:0] seg1_q,     seg1_d;
    logic        len_err_q,  len_err_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_send;        // datapath connected to the owner
    logic        w_accept;      // handshake on the shared stream
    logic [3:0]  w_pop;
    logic [16:0] w_sum;
    logic        w_last_beat;
    logic        w_can_grant;
    logic        w_grant_sel;

    // Reset gates the datapath so no handshake can complete in the cycle
    // that aborts a segment; the requester keeps its beat.
    assign w_send      = (state_q == ST_SEND) && !reset;
    assign w_accept    = tx_user_tvalid && tx_user_tready;
    assign w_pop       = popcount8(tx_user_tkeep);
    assign w_sum       = {1'b0, byte_cnt_q} + {13'd0, w_pop};
    assign w_last_beat = w_accept &&
                         ((w_sum >= c_seg_bytes) || (tx_user_tkeep != 8'hFF));

    assign w_can_grant = (tcp_state == TCP_ESTABLISHED) && (s0_tvalid || s1_tvalid);
    // On a tie the requester that did not finish last wins; otherwise the
    // only valid requester wins (s1_tvalid alone selects 1, s0 alone 0).
    assign w_grant_sel = (s0_tvalid && s1_tvalid) ? ~last_q : s1_tvalid;

    // Zero-latency mux between the owner and the shared stream.
    always_comb begin
        tx_user_tvalid = 1'b0;
        tx_user_tdata  = 64'd0;
        tx_user_tkeep  = 8'd0;
        s0_tready      = 1'b0;
        s1_tready      = 1'b0;
        if (w_send) begin
            if (owner_q) begin
                tx_user_tvalid = s1_tvalid;
                tx_user_tdata  = s1_tdata;
                tx_user_tkeep  = s1_tkeep;
                s1_tready      = tx_user_tready;
            end else begin
                tx_user_tvalid = s0_tvalid;
                tx_user_tdata  = s0_tdata;
                tx_user_tkeep  = s0_tkeep;
                s0_tready      = tx_user_tready;
            end
        end
    end

    // Next-state: arbitrate in IDLE, track bytes and segment end in SEND.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        byte_cnt_d = byte_cnt_q;
        seg0_d     = seg0_q;
        seg1_d     = seg1_q;
        len_err_d  = len_err_q;

        case (state_q)
            ST_IDLE: begin
                if (w_can_grant) begin
                    owner_d = w_grant_sel;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                // tcp_state is deliberately ignored here: a started segment
                // always runs to its end.
                if (w_accept) begin
                    byte_cnt_d = w_sum[15:0];
                    if (!keep_is_contiguous(tx_user_tkeep)) begin
                        len_err_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        state_d    = ST_IDLE;
                        byte_cnt_d = 16'd0;
                        last_d     = owner_q;
                        if (owner_q) begin
                            seg1_d = seg1_q + 32'd1;
                        end else begin
                            seg0_d = seg0_q + 32'd1;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; last_q resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge coreclk_out) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            byte_cnt_q <= 16'd0;
            seg0_q     <= 32'd0;
            seg1_q     <= 32'd0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            byte_cnt_q <= byte_cnt_d;
            seg0_q     <= seg0_d;
            seg1_q     <= seg1_d;
            len_err_q  <= len_err_d;
        end
    end

    assign owner    = owner_q;
    assign busy     = (state_q == ST_SEND);
    assign seg_cnt0 = seg0_q;
    assign seg_cnt1 = seg1_q;
    assign len_err  = len_err_q;

endmodule
`default_nettype wire
